memory_readback: RTL



---
 rtl/memory_readback.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/memory_readback.sv
// Drains a full capture-RAM buffer in address order as a valid/ready stream.
// Optional running checksum of streamed samples: define MEM_READBACK_CHECKSUM_EN.
module memory_readback #(
   parameter int DATA_W     = 10,
   parameter int ADDR_W     = 16,
   parameter int RD_LATENCY = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     bank_sel,
   output logic                     rd_en,
   output logic [ADDR_W-1:0]        rd_addr,
   output logic                     rd_bank,
   input  logic [DATA_W-1:0]        rd_data,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic                     busy,
   output logic                     done,
   output logic [ADDR_W+DATA_W-1:0] checksum
);

   // state  | meaning
   // IDLE   | waiting for start
   // READ   | issuing RAM reads while credits (in-flight + queued < depth) remain
   // DRAIN  | all reads issued; streaming out the remaining samples
   // FINISH | one-cycle done pulse, then back to IDLE
   typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

   localparam int DEPTH = RD_LATENCY + 2;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t                 state_q, state_d;
   logic                   rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
   logic                   bank_q, bank_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic [RD_LATENCY-1:0]  pipe_q, pipe_d;
   logic [RD_LATENCY-1:0]  pipe_last_q, pipe_last_d;
   logic [CNT_W-1:0]       in_flight_q, in_flight_d;
   logic [CNT_W-1:0]       fifo_count_q, fifo_count_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [DATA_W:0]        fifo_mem_q [DEPTH];

   logic                   issue, issue_last, push, push_last, pop, head_last;
   logic [DATA_W:0]        head;
   logic [CNT_W:0]         occ_next;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign issue      = rd_en_q;
   assign issue_last = rd_en_q && (rd_addr_q == LAST_ADDR);
   assign push       = pipe_q[RD_LATENCY-1];
   assign push_last  = pipe_last_q[RD_LATENCY-1];
   assign head       = fifo_mem_q[rd_ptr_q];
   assign head_last  = head[DATA_W];
   assign out_valid  = (fifo_count_q != '0);
   assign pop        = out_valid && out_ready;
   assign out_data   = out_valid ? head[DATA_W-1:0] : '0;
   assign out_last   = out_valid && head_last;

   assign rd_en   = rd_en_q;
   assign rd_addr = rd_addr_q;
   assign rd_bank = bank_q;
   assign busy    = busy_q;
   assign done    = done_q;

   always_comb begin
      state_d      = state_q;
      bank_d       = bank_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      rd_addr_d    = issue ? rd_addr_q + ADDR_W'(1) : rd_addr_q;
      in_flight_d  = in_flight_q + CNT_W'(issue) - CNT_W'(push);
      fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d     = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d     = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      pipe_d[0]      = issue;
      pipe_last_d[0] = issue_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_d[i]      = pipe_q[i-1];
         pipe_last_d[i] = pipe_last_q[i-1];
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = READ;
               bank_d    = bank_sel;
               rd_addr_d = '0;
               busy_d    = 1'b1;
            end
         end
         READ: begin
            if (issue_last) state_d = DRAIN;
         end
         DRAIN: begin
            if (pop && head_last && fifo_count_d == '0 && in_flight_d == '0) begin
               state_d = FINISH;
               done_d  = 1'b1;
            end
         end
         FINISH: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Credit check on post-edge occupancy so the next cycle's read always has a FIFO slot.
      occ_next = (CNT_W+1)'(in_flight_d) + (CNT_W+1)'(fifo_count_d);
      rd_en_d  = (state_d == READ) && (occ_next < (CNT_W+1)'(DEPTH));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rd_en_q      <= 1'b0;
         rd_addr_q    <= '0;
         bank_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pipe_q       <= '0;
         pipe_last_q  <= '0;
         in_flight_q  <= '0;
         fifo_count_q <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         rd_en_q      <= rd_en_d;
         rd_addr_q    <= rd_addr_d;
         bank_q       <= bank_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pipe_q       <= pipe_d;
         pipe_last_q  <= pipe_last_d;
         in_flight_q  <= in_flight_d;
         fifo_count_q <= fifo_count_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= {push_last, rd_data};
   end

`ifdef MEM_READBACK_CHECKSUM_EN
   logic [ADDR_W+DATA_W-1:0] checksum_q, checksum_d;

   always_comb begin
      checksum_d = checksum_q;
      if (state_q == IDLE && start) checksum_d = '0;
      else if (pop)                 checksum_d = checksum_q + (ADDR_W+DATA_W)'(out_data);
   end

   always_ff @(posedge clk) begin
      if (rst) checksum_q <= '0;
      else     checksum_q <= checksum_d;
   end

   assign checksum = checksum_q;
`else
   assign checksum = '0;
`endif

endmodule
